// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
// Pure declarations: no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversample counter and 3-sample majority vote.
// Latency: 2 cycles line-to-sync, decision at edge_cnt==P/2+1; no backpressure (free running).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  line_sync_o,
    output logic                  bit_val_o,
    output logic                  decide_o,
    output logic                  bit_end_o
);

    logic [1:0]            sync_q;
    logic [1:0]            samp_q;
    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [PRESCALE_W-1:0] half;

    assign half        = prescale_i >> 1;
    assign line_sync_o = sync_q[1];
    assign decide_o    = run_i && (edge_cnt_q == half + 1'b1);
    assign bit_end_o   = run_i && (edge_cnt_q == prescale_i - 1'b1);
    // Third vote is the live synchronised line at the decision cycle.
    assign bit_val_o   = maj3(samp_q[0], samp_q[1], line_sync_o);

    always_comb begin
        edge_cnt_d = '0;
        if (run_i && !bit_end_o) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            samp_q     <= 2'b11;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], line_i};
            edge_cnt_q <= edge_cnt_d;
            if (run_i && (edge_cnt_q == half - 1'b1)) begin
                samp_q[0] <= line_sync_o;
            end
            if (run_i && (edge_cnt_q == half)) begin
                samp_q[1] <= line_sync_o;
            end
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime parity/stop config; frame FSM, shift register, error checks.
// Latency: result pulse one cycle after the last stop-bit decision; no backpressure, pulses are fire-and-forget.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_wire,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_enable,
    input  logic                  par_type,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] data_out_bus,
    output logic                  data_valid_out,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  stop2_q, stop2_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  busy_q, busy_d;
    logic                  frame_end;

    logic run, line_sync, bit_val, decide, bit_end;

    assign run = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .line_i      (data_in_wire),
        .run_i       (run),
        .prescale_i  (prescale_q),
        .line_sync_o (line_sync),
        .bit_val_o   (bit_val),
        .decide_o    (decide),
        .bit_end_o   (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        par_flag_d = par_flag_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        frame_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!line_sync) begin
                    state_d    = START;
                    prescale_d = (prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                                 PRESCALE_W'(MIN_PRESCALE) : prescale;
                    par_en_d   = par_enable;
                    par_type_d = par_type;
                    stop2_d    = stop2;
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d   = {bit_val, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // With P=4 decide and bit_end coincide, so test the updated count.
                if (bit_end && (bit_cnt_d == CNT_W'(DATA_WIDTH))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide && (bit_val != (^shreg_q ^ par_type_q))) begin
                    par_flag_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (decide && !bit_val) begin
                    serr_d  = 1'b1;
                    state_d = WAIT_HI;
                end else if (decide && (stop_idx_q || !stop2_q)) begin
                    frame_end = 1'b1;
                    state_d   = IDLE;
                    if (par_flag_q) begin
                        perr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        dout_d  = shreg_q;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            WAIT_HI: begin
                if (line_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prescale_q <= PRESCALE_W'(MIN_PRESCALE);
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            stop2_q    <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            par_flag_q <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stop2_q    <= stop2_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            par_flag_q <= par_flag_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out_bus   = dout_q;
    assign data_valid_out = valid_q;
    assign par_err        = perr_q;
    assign stop_err       = serr_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: hand-built frames, pulse counters and expected values.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in_wire;
    logic [7:0] prescale;
    logic       par_enable;
    logic       par_type;
    logic       stop2;
    logic [7:0] data_out_bus;
    logic       data_valid_out;
    logic       par_err;
    logic       stop_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_serr  = 0;
    int         n_multi = 0;
    int         busy_cycles = 0;
    logic [7:0] vals[$];

    uart_rx_cfg #(
        .DATA_WIDTH (8),
        .PRESCALE_W (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_wire   (data_in_wire),
        .prescale       (prescale),
        .par_enable     (par_enable),
        .par_type       (par_type),
        .stop2          (stop2),
        .data_out_bus   (data_out_bus),
        .data_valid_out (data_valid_out),
        .par_err        (par_err),
        .stop_err       (stop_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid_out) begin
                n_valid++;
                vals.push_back(data_out_bus);
            end
            if (par_err)  n_perr++;
            if (stop_err) n_serr++;
            if ((int'(data_valid_out) + int'(par_err) + int'(stop_err)) > 1) n_multi++;
            if (busy) busy_cycles++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int cycles);
        data_in_wire = b;
        repeat (cycles) @(negedge clk);
    endtask

    // Start bit, data LSB first, optional parity; stop bits are left to the caller.
    task automatic send_data(input logic [7:0] d, input int p, input bit pen, input logic pbit);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic pen, input logic pt, input logic s2);
        prescale   = p;
        par_enable = pen;
        par_type   = pt;
        stop2      = s2;
    endtask

    int v0, pe0, se0, b0, q0;

    task automatic snap();
        v0  = n_valid;
        pe0 = n_perr;
        se0 = n_serr;
        b0  = busy_cycles;
        q0  = vals.size();
    endtask

    initial begin
        rst          = 1'b1;
        data_in_wire = 1'b1;
        set_cfg(8'd8, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("rst_dout",  32'(data_out_bus), 32'h0);
        chk("rst_valid", 32'(data_valid_out), 32'h0);
        chk("rst_perr",  32'(par_err), 32'h0);
        chk("rst_serr",  32'(stop_err), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: P=8 even parity, 0x4B, parity bit 0
        set_cfg(8'd8, 1'b1, 1'b0, 1'b0);
        snap();
        send_data(8'h4B, 8, 1'b1, 1'b0);
        drive_bit(1'b1, 24);
        chk("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("t1_data", 32'(vals.size() > q0 ? vals[q0] : 8'h00), 32'h4B);
        chk("t1_dout_hold", 32'(data_out_bus), 32'h4B);
        chk("t1_errs", 32'((n_perr - pe0) + (n_serr - se0)), 32'd0);
        chk("t1_busy_len_ok", 32'((busy_cycles - b0) >= 84 && (busy_cycles - b0) <= 92), 32'd1);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // 2: odd parity expected 1, sent 0
        set_cfg(8'd8, 1'b1, 1'b1, 1'b0);
        snap();
        send_data(8'h4B, 8, 1'b1, 1'b0);
        drive_bit(1'b1, 24);
        chk("t2_perr_cnt", 32'(n_perr - pe0), 32'd1);
        chk("t2_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("t2_dout_hold", 32'(data_out_bus), 32'h4B);

        // 3: P=16 stop bit low, line held low, then recovery frame 0xA5
        set_cfg(8'd16, 1'b0, 1'b0, 1'b0);
        snap();
        send_data(8'h55, 16, 1'b0, 1'b0);
        drive_bit(1'b0, 16 + 40);
        chk("t3_serr_cnt", 32'(n_serr - se0), 32'd1);
        chk("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("t3_busy_low", 32'(busy), 32'd1);
        drive_bit(1'b1, 20);
        chk("t3_busy_rel", 32'(busy), 32'd0);
        snap();
        send_data(8'hA5, 16, 1'b0, 1'b0);
        drive_bit(1'b1, 32);
        chk("t3_a5_valid", 32'(n_valid - v0), 32'd1);
        chk("t3_a5_data", 32'(data_out_bus), 32'hA5);

        // 4: 2-cycle glitch
        set_cfg(8'd8, 1'b0, 1'b0, 1'b0);
        snap();
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 8);
        chk("t4_busy_rel", 32'(busy), 32'd0);
        chk("t4_busy_seen", 32'((busy_cycles - b0) > 0), 32'd1);
        chk("t4_pulses", 32'((n_valid - v0) + (n_perr - pe0) + (n_serr - se0)), 32'd0);

        // 5: two stop bits, back-to-back 0x00 / 0xFF, then bad second stop
        set_cfg(8'd8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        snap();
        send_data(8'h00, 8, 1'b0, 1'b0);
        drive_bit(1'b1, 16);
        send_data(8'hFF, 8, 1'b0, 1'b0);
        drive_bit(1'b1, 24);
        chk("t5_valid_cnt", 32'(n_valid - v0), 32'd2);
        chk("t5_first", 32'(vals.size() > q0 ? vals[q0] : 8'h5A), 32'h00);
        chk("t5_second", 32'(vals.size() > q0 + 1 ? vals[q0 + 1] : 8'h5A), 32'hFF);
        snap();
        send_data(8'h5A, 8, 1'b0, 1'b0);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 24);
        chk("t5_stop2_serr", 32'(n_serr - se0), 32'd1);
        chk("t5_stop2_valid", 32'(n_valid - v0), 32'd0);

        // 6: async reset mid-DATA of 0x3C, then clean 0x3C
        set_cfg(8'd8, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dout", 32'(data_out_bus), 32'h00);
        data_in_wire = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send_data(8'h3C, 8, 1'b0, 1'b0);
        drive_bit(1'b1, 24);
        chk("t6_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("t6_data", 32'(data_out_bus), 32'h3C);

        chk("pulse_exclusive", 32'(n_multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
